// File: rtl/fine_code_lock_monitor.sv
// Re-times the asynchronous fine-tune code into ref_clk through a two-sample stability filter,
// declares frequency lock when the code dwells inside a window, and flags codes near either rail.
module fine_code_lock_monitor #(
   parameter int CODE_W      = 8,
   parameter int TICK_SHIFT  = 8,
   parameter int RAIL_MARGIN = 16
) (
   input  logic              ref_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [CODE_W-1:0] fine_code_in,
   input  logic [3:0]        lock_tol,
   input  logic [7:0]        lock_len,
   input  logic              hold_on_lock,
   output logic [CODE_W-1:0] fine_code_out,
   output logic              code_upd,
   output logic              locked,
   output logic              lock_lost,
   output logic              rail_hi,
   output logic              rail_lo
);

   localparam int DW          = CODE_W + 1;
   localparam int RAIL_HI_INT = (1 << CODE_W) - RAIL_MARGIN;
   localparam logic [CODE_W-1:0] CODE_RST   = {1'b1, {(CODE_W-1){1'b0}}};
   localparam logic [CODE_W:0]   RAIL_HI_TH = RAIL_HI_INT[CODE_W:0];
   localparam logic [CODE_W:0]   RAIL_LO_TH = RAIL_MARGIN[CODE_W:0];

   typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCKED} state_t;

   state_t                state;
   logic [CODE_W-1:0]     s1;
   logic [CODE_W-1:0]     s2;
   logic [CODE_W-1:0]     acc;
   logic [CODE_W-1:0]     anchor;
   logic [CODE_W-1:0]     frz;
   logic [7:0]            run_cnt;
   logic [TICK_SHIFT-1:0] tick_cnt;
   logic                  tick;
   logic                  accept;
   logic [CODE_W:0]       dev;
   logic [4:0]            tol_x2;
   logic                  out_of_win;
   logic                  out_of_hyst;

   function automatic logic [CODE_W:0] abs_diff(input logic [CODE_W-1:0] a,
                                                 input logic [CODE_W-1:0] b);
      logic signed [CODE_W+1:0] d;
      d = $signed({2'b00, a}) - $signed({2'b00, b});
      if (d < 0) d = -d;
      return d[CODE_W:0];
   endfunction

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // A code is taken only after two identical consecutive samples, so a bus caught mid-transition
   // or a single-cycle transient never reaches acc.
   assign accept      = (s1 == s2) && (s2 != acc);
   assign tick        = &tick_cnt;
   assign dev         = abs_diff(acc, anchor);
   assign tol_x2      = {lock_tol, 1'b0};
   assign out_of_win  = code_upd && (dev > DW'(lock_tol));
   assign out_of_hyst = code_upd && (dev > DW'(tol_x2));

   // Stage: synchroniser, acceptance, tick timer and rail flags
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= CODE_RST;
         s2       <= CODE_RST;
         acc      <= CODE_RST;
         code_upd <= 1'b0;
         tick_cnt <= '0;
         rail_hi  <= 1'b0;
         rail_lo  <= 1'b0;
      end else begin
         s1       <= fine_code_in;
         s2       <= s1;
         code_upd <= accept;
         if (accept) acc <= s2;
         tick_cnt <= tick_cnt + 1'b1;
         rail_hi  <= ({1'b0, acc} >= RAIL_HI_TH);
         rail_lo  <= ({1'b0, acc} <  RAIL_LO_TH);
      end
   end

   // Stage: lock state machine and oscillator code register
   always_ff @(posedge ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_IDLE;
         run_cnt       <= '0;
         anchor        <= CODE_RST;
         frz           <= CODE_RST;
         fine_code_out <= CODE_RST;
         locked        <= 1'b0;
         lock_lost     <= 1'b0;
      end else begin
         lock_lost <= 1'b0;
         if (!en) begin
            state         <= ST_IDLE;
            run_cnt       <= '0;
            anchor        <= acc;
            locked        <= 1'b0;
            fine_code_out <= acc;
         end else begin
            case (state)
               ST_IDLE: begin
                  state         <= ST_ACQ;
                  run_cnt       <= '0;
                  anchor        <= acc;
                  locked        <= 1'b0;
                  fine_code_out <= acc;
               end
               ST_ACQ: begin
                  locked        <= 1'b0;
                  fine_code_out <= acc;
                  // A re-anchor wins over both a coincident tick and a pending lock.
                  if (out_of_win) begin
                     anchor  <= acc;
                     run_cnt <= '0;
                  end else begin
                     if (tick) run_cnt <= sat_inc(run_cnt);
                     if ((lock_len != 8'd0) && (run_cnt >= lock_len)) begin
                        state  <= ST_LOCKED;
                        frz    <= acc;
                        locked <= 1'b1;
                     end
                  end
               end
               ST_LOCKED: begin
                  if (out_of_hyst) begin
                     state         <= ST_ACQ;
                     lock_lost     <= 1'b1;
                     locked        <= 1'b0;
                     anchor        <= acc;
                     run_cnt       <= '0;
                     fine_code_out <= acc;
                  end else begin
                     locked        <= 1'b1;
                     fine_code_out <= hold_on_lock ? frz : acc;
                  end
               end
               default: begin
                  state         <= ST_IDLE;
                  locked        <= 1'b0;
                  fine_code_out <= acc;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fine_code_lock_monitor.sv
// Directed and randomized bench for fine_code_lock_monitor against a cycle-level behavioural model.
module tb_fine_code_lock_monitor;

   localparam int TS   = 4;
   localparam int RM   = 16;
   localparam int TMAX = (1 << TS) - 1;

   logic       ref_clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [7:0] fine_code_in;
   logic [3:0] lock_tol;
   logic [7:0] lock_len;
   logic       hold_on_lock;
   logic [7:0] fine_code_out;
   logic       code_upd, locked, lock_lost, rail_hi, rail_lo;

   int checks = 0;
   int errors = 0;

   fine_code_lock_monitor #(.CODE_W(8), .TICK_SHIFT(TS), .RAIL_MARGIN(RM)) dut (
      .ref_clk      (ref_clk),
      .rst_n        (rst_n),
      .en           (en),
      .fine_code_in (fine_code_in),
      .lock_tol     (lock_tol),
      .lock_len     (lock_len),
      .hold_on_lock (hold_on_lock),
      .fine_code_out(fine_code_out),
      .code_upd     (code_upd),
      .locked       (locked),
      .lock_lost    (lock_lost),
      .rail_hi      (rail_hi),
      .rail_lo      (rail_lo)
   );

   always #5 ref_clk = ~ref_clk;

   // Reference model: m_* is the state after the last edge, n_* the state after the next one.
   logic [7:0] m_s1, m_s2, m_acc, m_anchor, m_frz, m_out;
   logic [7:0] n_s1, n_s2, n_acc, n_anchor, n_frz, n_out;
   int         m_run, m_tcnt, n_run, n_tcnt;
   logic       m_upd, m_locked, m_lost, m_rhi, m_rlo, m_trk;
   logic       n_upd, n_locked, n_lost, n_rhi, n_rlo, n_trk;

   task automatic model_reset();
      m_s1 = 8'h80; m_s2 = 8'h80; m_acc = 8'h80; m_anchor = 8'h80; m_frz = 8'h80; m_out = 8'h80;
      m_run = 0; m_tcnt = 0;
      m_upd = 1'b0; m_locked = 1'b0; m_lost = 1'b0; m_rhi = 1'b0; m_rlo = 1'b0; m_trk = 1'b0;
   endtask

   task automatic model_eval();
      int  dev;
      int  tol;
      bit  tick;
      dev  = int'(m_acc) - int'(m_anchor);
      if (dev < 0) dev = -dev;
      tol  = int'(lock_tol);
      tick = (m_tcnt == TMAX);
      n_s1   = fine_code_in;
      n_s2   = m_s1;
      n_upd  = (m_s1 == m_s2) && (m_s2 != m_acc);
      n_acc  = n_upd ? m_s2 : m_acc;
      n_tcnt = (m_tcnt + 1) % (TMAX + 1);
      n_anchor = m_anchor; n_run = m_run; n_frz = m_frz;
      n_trk = m_trk; n_locked = m_locked; n_lost = 1'b0;
      if (!en || !m_trk) begin
         n_trk = en; n_locked = 1'b0; n_run = 0; n_anchor = m_acc;
      end else if (!m_locked) begin
         if (m_upd && dev > tol) begin
            n_anchor = m_acc; n_run = 0;
         end else begin
            if (tick) n_run = (m_run < 255) ? m_run + 1 : 255;
            if (lock_len != 8'd0 && m_run >= int'(lock_len)) begin
               n_locked = 1'b1; n_frz = m_acc;
            end
         end
      end else if (m_upd && dev > 2 * tol) begin
         n_locked = 1'b0; n_lost = 1'b1; n_anchor = m_acc; n_run = 0;
      end
      n_out = (n_locked && hold_on_lock) ? n_frz : m_acc;
      n_rhi = (int'(m_acc) >= 256 - RM);
      n_rlo = (int'(m_acc) < RM);
   endtask

   task automatic model_commit();
      m_s1 = n_s1; m_s2 = n_s2; m_acc = n_acc; m_anchor = n_anchor; m_frz = n_frz; m_out = n_out;
      m_run = n_run; m_tcnt = n_tcnt;
      m_upd = n_upd; m_locked = n_locked; m_lost = n_lost; m_rhi = n_rhi; m_rlo = n_rlo;
      m_trk = n_trk;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      chk8("model_out", fine_code_out, m_out);
      chk1("model_upd", code_upd, m_upd);
      chk1("model_locked", locked, m_locked);
      chk1("model_lost", lock_lost, m_lost);
      chk1("model_rail_hi", rail_hi, m_rhi);
      chk1("model_rail_lo", rail_lo, m_rlo);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         model_eval();
         @(posedge ref_clk);
         #1;
         model_commit();
         check_model();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; fine_code_in = 8'h80;
      lock_tol = 4'd2; lock_len = 8'd4; hold_on_lock = 1'b0;
      model_reset();
      repeat (3) @(posedge ref_clk);
      #1;
      check_model();
      chk8("rst_out", fine_code_out, 8'h80);
      chk1("rst_locked", locked, 1'b0);
      rst_n = 1'b1;

      // Reset and filter
      fine_code_in = 8'h85;
      cyc(2);
      chk1("upd_before_k2", code_upd, 1'b0);
      cyc(1);
      chk1("upd_at_k2", code_upd, 1'b1);
      chk8("out_at_k2", fine_code_out, 8'h80);
      cyc(1);
      chk8("out_at_k3", fine_code_out, 8'h85);
      chk1("upd_at_k3", code_upd, 1'b0);
      fine_code_in = 8'hFF;
      cyc(1);
      fine_code_in = 8'h85;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk1("glitch_upd", code_upd, 1'b0);
         chk8("glitch_out", fine_code_out, 8'h85);
      end

      // Lock acquisition with a re-anchor step
      lock_tol = 4'd2; lock_len = 8'd4; hold_on_lock = 1'b1;
      fine_code_in = 8'h90; en = 1'b1;
      cyc(40);
      chk1("pre_lock", locked, 1'b0);
      fine_code_in = 8'h94;
      cyc(40);
      chk1("reanchor_no_lock", locked, 1'b0);
      for (int r = 0; r < 3; r++) begin
         fine_code_in = 8'h90; cyc(5);
         fine_code_in = 8'h91; cyc(5);
      end
      fine_code_in = 8'h90;
      for (int i = 0; i < 120 && !locked; i++) cyc(1);
      chk1("lock_acquired", locked, 1'b1);
      chk8("lock_out", fine_code_out, 8'h90);

      // Hold and hysteresis
      fine_code_in = 8'h94;
      cyc(6);
      chk1("hyst_in_window_locked", locked, 1'b1);
      chk8("hyst_frozen_out", fine_code_out, 8'h90);
      fine_code_in = 8'h95;
      for (int i = 0; i < 10 && !lock_lost; i++) cyc(1);
      chk1("lost_pulse", lock_lost, 1'b1);
      chk1("lost_unlocked", locked, 1'b0);
      chk8("lost_out", fine_code_out, 8'h95);
      cyc(1);
      chk1("lost_one_cycle", lock_lost, 1'b0);

      // Rail flags
      en = 1'b0;
      fine_code_in = 8'hF0; cyc(4);
      chk1("rail_hi_F0", rail_hi, 1'b1);
      fine_code_in = 8'hEF; cyc(4);
      chk1("rail_hi_EF", rail_hi, 1'b0);
      fine_code_in = 8'h0F; cyc(4);
      chk1("rail_lo_0F", rail_lo, 1'b1);
      fine_code_in = 8'h10; cyc(4);
      chk1("rail_lo_10", rail_lo, 1'b0);

      // Re-anchor coincident with a tick must leave the run counter at zero
      hold_on_lock = 1'b0; lock_tol = 4'd2; lock_len = 8'd3;
      fine_code_in = 8'h50;
      cyc(6);
      for (int i = 0; i < 20 && m_tcnt != 12; i++) cyc(1);
      en = 1'b1; fine_code_in = 8'h60;
      cyc(3);
      chk1("prio_upd", code_upd, 1'b1);
      cyc(40);
      chk1("prio_no_early_lock", locked, 1'b0);
      cyc(12);
      chk1("prio_lock", locked, 1'b1);

      // Enable drop wins over a coincident lock loss
      fine_code_in = 8'h70;
      cyc(3);
      chk1("endrop_upd", code_upd, 1'b1);
      en = 1'b0;
      cyc(1);
      chk1("endrop_no_lost", lock_lost, 1'b0);
      chk1("endrop_unlocked", locked, 1'b0);
      chk8("endrop_out", fine_code_out, 8'h70);

      // lock_len of zero never locks
      en = 1'b1; lock_len = 8'd0;
      for (int i = 0; i < 100; i++) begin
         cyc(1);
         chk1("len0_no_lock", locked, 1'b0);
      end

      // Asynchronous reset while locked
      lock_len = 8'd2; hold_on_lock = 1'b1;
      for (int i = 0; i < 80 && !locked; i++) cyc(1);
      chk1("relock", locked, 1'b1);
      fine_code_in = 8'h33;
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk8("arst_out", fine_code_out, 8'h80);
      chk1("arst_locked", locked, 1'b0);
      chk1("arst_upd", code_upd, 1'b0);
      chk1("arst_lost", lock_lost, 1'b0);
      chk1("arst_rail_hi", rail_hi, 1'b0);
      chk1("arst_rail_lo", rail_lo, 1'b0);
      #2;
      rst_n = 1'b1;
      cyc(10);

      // Randomized wander against the model
      begin
         int center;
         center = 128;
         for (int r = 0; r < 150; r++) begin
            int c;
            c = center + int'($urandom_range(0, 10)) - 5;
            if (c < 0) c = 0;
            if (c > 255) c = 255;
            fine_code_in = 8'(c);
            if ($urandom_range(0, 9) == 0) center = int'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) hold_on_lock = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 11) == 0) lock_tol = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 11) == 0) lock_len = 8'($urandom_range(0, 3));
            cyc(int'($urandom_range(1, 8)));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
